// File: rtl/lspuf_ctrl.sv
// Lightweight-secure PUF evaluation controller: drives a challenge into the PUF,
// fires it NUM_EVAL times and majority-votes the 19 response bits.
module lspuf_ctrl #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int NUM_EVAL    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chal_valid,
  output logic        chal_ready,
  input  logic [15:0] chal_in,
  output logic [15:0] puf_c,
  output logic        puf_tig,
  input  logic        puf_resp_ready,
  input  logic [9:0]  puf_resp_a,
  input  logic [8:0]  puf_resp_s,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [9:0]  res_a,
  output logic [8:0]  res_s,
  output logic        res_timeout,
  output logic        busy
);

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  EVAL_LAST    = 3'(NUM_EVAL - 1);
  localparam logic [2:0]  VOTE_HALF    = 3'(NUM_EVAL / 2);

  typedef enum logic [2:0] {IDLE, SETUP, FIRE, RELAX, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  settle_cnt;
  logic [15:0] timeout_cnt;
  logic [2:0]  eval_cnt;
  logic [2:0]  vote_cnt [0:18];
  logic        timeout_flag;
  logic [18:0] resp_bits;
  logic [18:0] majority;

  assign resp_bits  = {puf_resp_a, puf_resp_s};
  assign chal_ready = (state == IDLE) && !rst;
  assign busy       = (state != IDLE);
  assign puf_tig    = (state == FIRE);
  assign res_valid  = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (chal_valid) state_next = SETUP;
      SETUP: if (settle_cnt == SETTLE_LAST) state_next = FIRE;
      FIRE:  if (puf_resp_ready || timeout_cnt == TIMEOUT_LAST) state_next = RELAX;
      RELAX: if (!puf_resp_ready) state_next = (eval_cnt == EVAL_LAST) ? DONE : SETUP;
      DONE:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    majority = '0;
    for (int i = 0; i < 19; i++) majority[i] = (vote_cnt[i] > VOTE_HALF);
  end

  // A response arriving on the final timeout cycle still counts as a vote.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      puf_c        <= '0;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
      eval_cnt     <= '0;
      timeout_flag <= 1'b0;
      res_a        <= '0;
      res_s        <= '0;
      res_timeout  <= 1'b0;
      for (int i = 0; i < 19; i++) vote_cnt[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (chal_valid) begin
            puf_c        <= chal_in;
            settle_cnt   <= '0;
            timeout_cnt  <= '0;
            eval_cnt     <= '0;
            timeout_flag <= 1'b0;
            for (int i = 0; i < 19; i++) vote_cnt[i] <= '0;
          end
        end
        SETUP: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt  <= '0;
            timeout_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        FIRE: begin
          if (puf_resp_ready) begin
            for (int i = 0; i < 19; i++)
              if (resp_bits[i]) vote_cnt[i] <= vote_cnt[i] + 3'd1;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            timeout_flag <= 1'b1;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        RELAX: begin
          if (!puf_resp_ready) begin
            eval_cnt <= eval_cnt + 3'd1;
            if (eval_cnt == EVAL_LAST) begin
              res_a       <= majority[18:9];
              res_s       <= majority[8:0];
              res_timeout <= timeout_flag;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lspuf_ctrl.sv
// Directed self-checking bench for lspuf_ctrl with a scripted PUF response model.
module tb_lspuf_ctrl;

  localparam int SETTLE = 4;
  localparam int TMO    = 10;
  localparam int NEV    = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        chal_valid;
  logic        chal_ready;
  logic [15:0] chal_in;
  logic [15:0] puf_c;
  logic        puf_tig;
  logic        puf_resp_ready;
  logic [9:0]  puf_resp_a;
  logic [8:0]  puf_resp_s;
  logic        res_valid;
  logic        res_ready;
  logic [9:0]  res_a;
  logic [8:0]  res_s;
  logic        res_timeout;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  logic [9:0] tab_a [NEV];
  logic [8:0] tab_s [NEV];

  lspuf_ctrl #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .NUM_EVAL(NEV)) dut (
    .clk(clk), .rst(rst),
    .chal_valid(chal_valid), .chal_ready(chal_ready), .chal_in(chal_in),
    .puf_c(puf_c), .puf_tig(puf_tig),
    .puf_resp_ready(puf_resp_ready), .puf_resp_a(puf_resp_a), .puf_resp_s(puf_resp_s),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_a(res_a), .res_s(res_s), .res_timeout(res_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; chal_valid = 1'b0; chal_in = '0; res_ready = 1'b0;
    puf_resp_ready = 1'b0; puf_resp_a = '0; puf_resp_s = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({chal_ready, busy, puf_tig, res_valid, res_timeout} !== 5'b0) begin
      fails++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000",
               {chal_ready, busy, puf_tig, res_valid, res_timeout});
    end
    checks++;
    if ({puf_c, res_a, res_s} !== 35'h0) begin
      fails++;
      $display("[TB] FAIL reset_data: got %h expected 0", {puf_c, res_a, res_s});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (chal_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", chal_ready);
    end
  endtask

  task automatic accept(input logic [15:0] chal);
    chal_valid = 1'b1;
    chal_in    = chal;
    checks++;
    if (chal_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accept_ready: got %b expected 1", chal_ready);
    end
    @(negedge clk);
    chal_valid = 1'b0;
    checks++;
    if (puf_c !== chal || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL accept_latch: got puf_c=%h busy=%b expected %h 1", puf_c, busy, chal);
    end
  endtask

  // Runs n_run evaluations; respond=0 means the PUF never answers.
  task automatic run_evals(input int n_run, input bit respond, input int hold);
    int cnt;
    int pulses;
    pulses = 0;
    for (int e = 0; e < n_run; e++) begin
      cnt = 0;
      while (puf_tig !== 1'b1 && cnt < 100) begin
        @(negedge clk);
        cnt++;
      end
      checks++;
      if (cnt != ((e == 0) ? SETTLE : SETTLE + 1)) begin
        fails++;
        $display("[TB] FAIL settle_gap eval %0d: got %0d cycles expected %0d",
                 e, cnt, (e == 0) ? SETTLE : SETTLE + 1);
        if (cnt >= 100) return;
      end
      pulses++;
      if (respond) begin
        repeat (3) @(negedge clk);
        checks++;
        if (puf_tig !== 1'b1) begin
          fails++;
          $display("[TB] FAIL tig_held eval %0d: got %b expected 1", e, puf_tig);
        end
        puf_resp_ready = 1'b1;
        puf_resp_a     = tab_a[e];
        puf_resp_s     = tab_s[e];
        @(negedge clk);
        checks++;
        if (puf_tig !== 1'b0) begin
          fails++;
          $display("[TB] FAIL fire_end eval %0d: got %b expected 0", e, puf_tig);
        end
        for (int h = 1; h < hold; h++) begin
          @(negedge clk);
          checks++;
          if (puf_tig !== 1'b0 || res_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL stuck_relax eval %0d: got tig=%b valid=%b expected 0 0",
                     e, puf_tig, res_valid);
          end
        end
        puf_resp_ready = 1'b0;
        puf_resp_a     = '0;
        puf_resp_s     = '0;
      end else begin
        cnt = 0;
        while (puf_tig === 1'b1 && cnt < 100) begin
          @(negedge clk);
          cnt++;
        end
        checks++;
        if (cnt != TMO) begin
          fails++;
          $display("[TB] FAIL fire_len eval %0d: got %0d expected %0d", e, cnt, TMO);
        end
      end
    end
    checks++;
    if (pulses != n_run) begin
      fails++;
      $display("[TB] FAIL pulse_count: got %0d expected %0d", pulses, n_run);
    end
  endtask

  task automatic collect(input logic [9:0] ea, input logic [8:0] es, input logic eto,
                         input int bp_cycles);
    int cnt;
    cnt = 0;
    while (res_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (cnt != 1) begin
      fails++;
      $display("[TB] FAIL done_latency: got %0d expected 1", cnt);
    end
    checks++;
    if (res_a !== ea || res_s !== es || res_timeout !== eto) begin
      fails++;
      $display("[TB] FAIL result: got a=%h s=%h to=%b expected a=%h s=%h to=%b",
               res_a, res_s, res_timeout, ea, es, eto);
    end
    checks++;
    if (chal_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL done_flags: got ready=%b busy=%b expected 0 1", chal_ready, busy);
    end
    for (int i = 0; i < bp_cycles; i++) begin
      chal_valid = 1'b1;
      chal_in    = 16'h1234;
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || chal_ready !== 1'b0 || res_a !== ea || res_s !== es ||
          res_timeout !== eto || puf_c === 16'h1234) begin
        fails++;
        $display("[TB] FAIL backpressure cycle %0d: got valid=%b ready=%b a=%h s=%h c=%h expected 1 0 %h %h",
                 i, res_valid, chal_ready, res_a, res_s, puf_c, ea, es);
      end
    end
    chal_valid = 1'b0;
    res_ready  = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || chal_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL release_idle: got valid=%b ready=%b busy=%b expected 0 1 0",
               res_valid, chal_ready, busy);
    end
  endtask

  task automatic test_normal();
    for (int e = 0; e < NEV; e++) begin tab_a[e] = 10'h2AA; tab_s[e] = 9'h155; end
    accept(16'hafba);
    run_evals(NEV, 1'b1, 1);
    collect(10'h2AA, 9'h155, 1'b0, 0);
  endtask

  task automatic test_majority();
    for (int e = 0; e < NEV; e++) begin
      tab_s[e] = (e % 2 == 0) ? 9'h1FF : 9'h000;
      tab_a[e] = (e < 3) ? 10'h3FF : 10'h000;
    end
    accept(16'h0f0f);
    run_evals(NEV, 1'b1, 1);
    collect(10'h3FF, 9'h1FF, 1'b0, 0);
    for (int e = 0; e < NEV; e++) begin
      tab_s[e] = (e % 2 == 0) ? 9'h000 : 9'h1FF;
      tab_a[e] = (e < 2) ? 10'h155 : 10'h2AA;
    end
    accept(16'hf0f0);
    run_evals(NEV, 1'b1, 1);
    collect(10'h2AA, 9'h000, 1'b0, 0);
  endtask

  task automatic test_timeout();
    accept(16'h1357);
    run_evals(NEV, 1'b0, 1);
    collect(10'h000, 9'h000, 1'b1, 0);
  endtask

  task automatic test_backpressure();
    for (int e = 0; e < NEV; e++) begin tab_a[e] = 10'h0F3; tab_s[e] = 9'h0A5; end
    accept(16'hbeef);
    run_evals(NEV, 1'b1, 1);
    collect(10'h0F3, 9'h0A5, 1'b0, 20);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || puf_c !== 16'hbeef) begin
      fails++;
      $display("[TB] FAIL ignored_chal: got busy=%b c=%h expected 0 beef", busy, puf_c);
    end
  endtask

  task automatic test_stuck_ready();
    for (int e = 0; e < NEV; e++) begin
      tab_s[e] = (e < 2) ? 9'h1FF : 9'h000;
      tab_a[e] = (e < 3) ? 10'h3FF : 10'h000;
    end
    accept(16'h2468);
    run_evals(NEV, 1'b1, 5);
    collect(10'h3FF, 9'h000, 1'b0, 0);
  endtask

  task automatic test_reset_mid_fire();
    int cnt;
    for (int e = 0; e < NEV; e++) begin tab_a[e] = 10'h111; tab_s[e] = 9'h0EE; end
    accept(16'hc0de);
    run_evals(2, 1'b1, 1);
    cnt = 0;
    while (puf_tig !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (puf_tig !== 1'b1) begin
      fails++;
      $display("[TB] FAIL third_fire: got tig=%b expected 1", puf_tig);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (puf_tig !== 1'b0 || busy !== 1'b0 || chal_ready !== 1'b0 || puf_c !== 16'h0) begin
      fails++;
      $display("[TB] FAIL async_reset: got tig=%b busy=%b ready=%b c=%h expected 0 0 0 0",
               puf_tig, busy, chal_ready, puf_c);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("[TB] FAIL post_reset_quiet cycle %0d: got valid=%b busy=%b expected 0 0",
                 i, res_valid, busy);
      end
    end
    for (int e = 0; e < NEV; e++) begin tab_a[e] = 10'h2C3; tab_s[e] = 9'h13C; end
    accept(16'h5a5a);
    run_evals(NEV, 1'b1, 1);
    collect(10'h2C3, 9'h13C, 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_majority();
    test_timeout();
    test_backpressure();
    test_stuck_ready();
    test_reset_mid_fire();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
